// File: rtl/seq_slt_unit.sv
// -----------------------------------------------------------------------------
// seq_slt_unit
// Multicycle set-less-than unit. Compares two W-bit operands D bits per clock,
// walking from the least-significant chunk to the most-significant chunk with a
// registered less-than carry. A less-than carry-in turns the same datapath into
// a less-or-equal compare, and a final sign fix-up provides signed compares.
//
// Ports
//   clk          : single clock, rising-edge active
//   rst_n        : asynchronous active-low reset
//   start        : request, accepted on a rising edge only while busy = 0
//   a, b         : W-bit operands, captured on accept
//   signed_mode  : 1 = two's-complement compare, 0 = unsigned (captured)
//   lt_in        : less-than carry-in (0 -> a<b, 1 -> a<=b) (captured)
//   busy         : operation in progress
//   done         : one-cycle pulse, results valid
//   lt           : registered compare result
//   eq           : registered a == b
//   slt          : {W-1 zeros, lt}, ALU SLT word
// -----------------------------------------------------------------------------
module seq_slt_unit #(
   parameter int W = 32,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         signed_mode,
   input  logic         lt_in,
   output logic         busy,
   output logic         done,
   output logic         lt,
   output logic         eq,
   output logic [W-1:0] slt
);

   localparam int N  = W / D;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);
   localparam logic [KW-1:0] K_ONE  = KW'(1);
   localparam logic [KW-1:0] K_ZERO = KW'(0);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Reject operand/chunk geometries the chunk walk cannot cover exactly.
   generate
      if ((W < 2) || (D < 1) || ((W % D) != 0)) begin : g_bad_param
         $error("seq_slt_unit: W must be >= 2 and a multiple of D");
      end
   endgenerate

   logic [0:0]    state_r;
   logic [KW-1:0] k_r;
   logic [W-1:0]  a_r;
   logic [W-1:0]  b_r;
   logic          signed_r;
   logic          lt_acc_r;
   logic          eq_acc_r;
   logic          done_r;
   logic          lt_r;
   logic          eq_r;

   logic [D-1:0]  chunk_a_s;
   logic [D-1:0]  chunk_b_s;
   logic          lt_next_s;
   logic          eq_next_s;
   logic          sign_flip_s;

   // Select the current chunk and fold it into the running less-than/equal state.
   always_comb begin
      chunk_a_s   = a_r[int'(k_r) * D +: D];
      chunk_b_s   = b_r[int'(k_r) * D +: D];
      lt_next_s   = lt_acc_r;
      eq_next_s   = eq_acc_r & (chunk_a_s == chunk_b_s);
      // A differing higher chunk decides the order; equal chunks keep the
      // verdict of the lower chunks (or the carry-in if all are equal).
      if (chunk_a_s < chunk_b_s) begin
         lt_next_s = 1'b1;
      end else if (chunk_a_s > chunk_b_s) begin
         lt_next_s = 1'b0;
      end else begin
         lt_next_s = lt_acc_r;
      end
      // With differing sign bits the unsigned order is exactly inverted.
      sign_flip_s = signed_r & (a_r[W-1] ^ b_r[W-1]);
   end

   // Control FSM, operand capture, chunk walk and registered results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         k_r      <= K_ZERO;
         a_r      <= {W{1'b0}};
         b_r      <= {W{1'b0}};
         signed_r <= 1'b0;
         lt_acc_r <= 1'b0;
         eq_acc_r <= 1'b0;
         done_r   <= 1'b0;
         lt_r     <= 1'b0;
         eq_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  a_r      <= a;
                  b_r      <= b;
                  signed_r <= signed_mode;
                  lt_acc_r <= lt_in;
                  eq_acc_r <= 1'b1;
                  k_r      <= K_ZERO;
                  state_r  <= ST_BUSY;
               end else begin
                  state_r  <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               lt_acc_r <= lt_next_s;
               eq_acc_r <= eq_next_s;
               if (k_r == K_LAST) begin
                  lt_r    <= lt_next_s ^ sign_flip_s;
                  eq_r    <= eq_next_s;
                  done_r  <= 1'b1;
                  k_r     <= K_ZERO;
                  state_r <= ST_IDLE;
               end else begin
                  k_r     <= k_r + K_ONE;
                  state_r <= ST_BUSY;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               k_r     <= K_ZERO;
            end
         endcase
      end
   end

   assign busy = (state_r == ST_BUSY);
   assign done = done_r;
   assign lt   = lt_r;
   assign eq   = eq_r;
   assign slt  = {{(W-1){1'b0}}, lt_r};

endmodule

// File: tb/tb_seq_slt_unit.sv
// -----------------------------------------------------------------------------
// Bench for seq_slt_unit: four instances with different W/D share one stimulus
// stream (operands truncated per instance) and are checked against an
// arithmetic reference model of signed/unsigned less-than with carry-in.
// -----------------------------------------------------------------------------
module tb_seq_slt_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        signed_mode;
   logic        lt_in;
   logic [31:0] a_in;
   logic [31:0] b_in;

   logic        busy_v [4];
   logic        done_v [4];
   logic        lt_v   [4];
   logic        eq_v   [4];
   logic [31:0] slt0;
   logic [15:0] slt1;
   logic [7:0]  slt2;
   logic [7:0]  slt3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_slt_unit #(.W(32), .D(4)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a_in), .b(b_in),
      .signed_mode(signed_mode), .lt_in(lt_in), .busy(busy_v[0]),
      .done(done_v[0]), .lt(lt_v[0]), .eq(eq_v[0]), .slt(slt0));
   seq_slt_unit #(.W(16), .D(2)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[15:0]), .b(b_in[15:0]),
      .signed_mode(signed_mode), .lt_in(lt_in), .busy(busy_v[1]),
      .done(done_v[1]), .lt(lt_v[1]), .eq(eq_v[1]), .slt(slt1));
   seq_slt_unit #(.W(8), .D(8)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[7:0]), .b(b_in[7:0]),
      .signed_mode(signed_mode), .lt_in(lt_in), .busy(busy_v[2]),
      .done(done_v[2]), .lt(lt_v[2]), .eq(eq_v[2]), .slt(slt2));
   seq_slt_unit #(.W(8), .D(1)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a_in[7:0]), .b(b_in[7:0]),
      .signed_mode(signed_mode), .lt_in(lt_in), .busy(busy_v[3]),
      .done(done_v[3]), .lt(lt_v[3]), .eq(eq_v[3]), .slt(slt3));

   function automatic int w_of(input int i);
      case (i)
         0:       return 32;
         1:       return 16;
         default: return 8;
      endcase
   endfunction

   // Expected latency in cycles from accept edge to done: W/D.
   function automatic int n_of(input int i);
      case (i)
         0:       return 8;
         1:       return 8;
         2:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic logic [31:0] slt_of(input int i);
      case (i)
         0:       return slt0;
         1:       return {16'd0, slt1};
         2:       return {24'd0, slt2};
         default: return {24'd0, slt3};
      endcase
   endfunction

   // Reference: interpret the low w bits as signed or unsigned integers.
   function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input logic sm, input logic lin);
      longint mask;
      longint sa;
      longint sb;
      mask = (64'sd1 <<< w) - 64'sd1;
      sa   = longint'({32'd0, a}) & mask;
      sb   = longint'({32'd0, b}) & mask;
      if (sm && sa[w-1]) sa = sa - (64'sd1 <<< w);
      if (sm && sb[w-1]) sb = sb - (64'sd1 <<< w);
      return {((sa < sb) || (lin && (sa == sb))), (sa == sb)};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One operation on all instances; mask selects which instances are checked.
   // inject_at > 0 raises start with new operands during that busy cycle.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         input logic lin, input int inject_at, input logic [3:0] mask,
                         input string name);
      int          lat  [4];
      int          dcnt [4];
      logic [1:0]  exp  [4];
      @(negedge clk);
      a_in = a; b_in = b; signed_mode = sm; lt_in = lin; start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp[i]  = ref_cmp(a, b, w_of(i), sm, lin);
         lat[i]  = 0;
         dcnt[i] = 0;
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 4; i++)
         if (mask[i]) check($sformatf("%s busy_after_accept u%0d", name, i), {31'd0, busy_v[i]}, 32'd1);
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == inject_at) begin
            a_in = $urandom; b_in = $urandom; signed_mode = ~sm; lt_in = ~lin; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         for (int i = 0; i < 4; i++) begin
            if (done_v[i]) begin
               dcnt[i]++;
               if (lat[i] == 0) lat[i] = c;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            check($sformatf("%s latency u%0d", name, i), lat[i], n_of(i));
            check($sformatf("%s done_pulses u%0d", name, i), dcnt[i], 32'd1);
            check($sformatf("%s lt u%0d", name, i), {31'd0, lt_v[i]}, {31'd0, exp[i][1]});
            check($sformatf("%s eq u%0d", name, i), {31'd0, eq_v[i]}, {31'd0, exp[i][0]});
            check($sformatf("%s slt u%0d", name, i), slt_of(i), {31'd0, exp[i][1]});
         end
      end
   endtask

   initial begin
      int         cyc;
      int         npulse;
      int         last_c;
      int         bad_cnt;
      logic [31:0] ra;
      logic [31:0] rb;

      rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; lt_in = 1'b0;
      a_in = 32'd0; b_in = 32'd0;
      #3;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset busy u%0d", i), {31'd0, busy_v[i]}, 32'd0);
         check($sformatf("reset done u%0d", i), {31'd0, done_v[i]}, 32'd0);
         check($sformatf("reset lt u%0d", i), {31'd0, lt_v[i]}, 32'd0);
         check($sformatf("reset slt u%0d", i), slt_of(i), 32'd0);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Directed cases.
      run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, 0, 4'hF, "uns_lt");
      run_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b0, 0, 4'hF, "uns_gt");
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 0, 4'hF, "sgn_neg");
      run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 4'hF, "uns_big");
      run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 0, 4'hF, "sgn_min");
      run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 0, 4'hF, "eq_lt");
      run_op(32'h1234_5679, 32'h1234_5678, 1'b0, 1'b1, 0, 4'hF, "le_gt");
      run_op(32'h1000_0000, 32'h0FFF_FFFF, 1'b0, 1'b0, 0, 4'hF, "hi_override");
      run_op(32'h0000_0080, 32'h0000_0001, 1'b1, 1'b0, 0, 4'hF, "w8_sgn");
      // Start during busy is ignored by the N=8 units (the N=1 unit is idle then).
      run_op(32'h0000_0003, 32'h0000_0009, 1'b0, 1'b0, 4, 4'b1011, "busy_start");
      // Leaves lt=1, eq=1 so the reset clearing below is observable.
      run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 0, 4'hF, "eq_le");

      // Reset three cycles into an operation aborts it without a done pulse.
      @(negedge clk);
      a_in = 32'h0000_0005; b_in = 32'h0000_0007; signed_mode = 1'b0; lt_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst busy", {31'd0, busy_v[0]}, 32'd0);
      check("midrst done", {31'd0, done_v[0]}, 32'd0);
      check("midrst lt", {31'd0, lt_v[0]}, 32'd0);
      check("midrst eq", {31'd0, eq_v[0]}, 32'd0);
      check("midrst slt", slt0, 32'd0);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      check("start_in_reset busy", {31'd0, busy_v[0]}, 32'd0);
      @(negedge clk); start = 1'b0; rst_n = 1'b1;
      bad_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (done_v[0] || busy_v[0]) bad_cnt++;
      end
      check("post_reset no_done", bad_cnt, 32'd0);

      // Start held high with alternating operands: done every 9 cycles.
      @(negedge clk);
      a_in = 32'h0000_0005; b_in = 32'h0000_0007; signed_mode = 1'b0; lt_in = 1'b0; start = 1'b1;
      npulse = 0; last_c = 0; cyc = 0;
      @(posedge clk); #1;
      while ((npulse < 3) && (cyc < 40)) begin
         @(posedge clk); #1;
         cyc++;
         if (done_v[0]) begin
            check($sformatf("held interval %0d", npulse), cyc - last_c, (npulse == 0) ? 32'd8 : 32'd9);
            check($sformatf("held lt %0d", npulse), {31'd0, lt_v[0]}, (npulse % 2 == 0) ? 32'd1 : 32'd0);
            last_c = cyc;
            npulse++;
            a_in = (npulse % 2 == 0) ? 32'h0000_0005 : 32'h0000_0007;
            b_in = (npulse % 2 == 0) ? 32'h0000_0007 : 32'h0000_0005;
         end
      end
      check("held pulse count", npulse, 32'd3);
      @(negedge clk); start = 1'b0;
      repeat (12) @(posedge clk);

      // Randomized vectors against the reference model on all instances.
      for (int t = 0; t < 40; t++) begin
         ra = $urandom;
         case ($urandom_range(3))
            0:       rb = ra;
            1:       rb = ra ^ (32'd1 << $urandom_range(31));
            default: rb = $urandom;
         endcase
         run_op(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 4'hF,
                $sformatf("rand%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
